// File: rtl/arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and grant sides.
package arb_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE_I = 2'd1;
  localparam logic [1:0] ISSUE_D = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. The grant is combinational.
// last_grant advances only when the caller accepts the grant.
module rr_arb2 import arb_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_d,
  input  logic update,
  output logic gnt,
  output logic gnt_vld
);
  logic last_q, last_d;

  always_comb begin
    gnt_vld = req_i | req_d;
    if (req_i && req_d) gnt = (last_q == GRANT_I) ? GRANT_D : GRANT_I;
    else                gnt = req_d ? GRANT_D : GRANT_I;
    last_d = (update && gnt_vld) ? gnt : last_q;
  end

  // Reset to I so that D wins the first tie.
  always_ff @(posedge clk) begin
    if (rst_n) last_q <= GRANT_I;
    else       last_q <= last_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block-transfer memory port between the I-cache and D-cache refill paths.
// One transaction is in flight at a time. All memory-side and ready/rdata outputs are registered.
module mem_port_arbiter import arb_pkg::*; #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);
  logic [1:0]        state_q, state_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic              d_req, gnt, gnt_vld, gnt_en;

  assign d_req  = d_read | d_write;
  assign gnt_en = (state_q == IDLE) && gnt_vld;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (i_read),
    .req_d   (d_req),
    .update  (gnt_en),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = (gnt == GRANT_D) ? ISSUE_D : ISSUE_I;
      ISSUE_I,
      ISSUE_D: if (mem_ready) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    case (state_q)
      IDLE: if (gnt_vld) begin
        // d_write wins if the D side illegally raises both strobes.
        if (gnt == GRANT_D) begin
          mem_addr_d  = d_addr;
          mem_write_d = d_write;
          mem_read_d  = ~d_write;
          mem_wdata_d = d_write ? d_wdata : '0;
        end else begin
          mem_addr_d  = i_addr;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_wdata_d = '0;
        end
      end
      ISSUE_I: if (mem_ready) begin
        i_rdata_d  = mem_rdata;
        i_ready_d  = 1'b1;
        mem_read_d = 1'b0;
      end
      ISSUE_D: if (mem_ready) begin
        if (mem_read_q) d_rdata_d = mem_rdata;
        d_ready_d   = 1'b1;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level owner/response model,
// with a latency-programmable memory responder and directed reset/priority scenarios.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  // Reference model: who owns the port (0 none, 1 I, 2 D), who gets a ready pulse, last winner.
  int            m_owner = 0, m_resp = 0, m_last = 1;
  logic          m_rd = 0, m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_irdata = '0, m_drdata = '0;

  // Requesters and memory responder.
  int            i_mode = 0, d_mode = 0;
  bit            i_pend = 0, d_pend = 0, d_is_wr = 0, d_both = 0;
  bit            mo_out = 0, spur_en = 0, rd_fix_en = 0, rst_req = 1, strobe_prev = 0;
  int            mo_cnt = 0, lat_fix = 0;
  logic [DW-1:0] rd_fix = '0;
  int            n_irdy = 0, n_drdy = 0;
  int            dut_log[$];

  task automatic drive_mem();
    if (mem_ready) begin mem_ready = 1'b0; mo_out = 0; end
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if ((mem_read || mem_write) && !mo_out) begin
      mo_out = 1;
      mo_cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
    end
    if (mo_out) begin
      mo_cnt--;
      if (mo_cnt == 0) begin
        mem_ready = 1'b1;
        if (rd_fix_en) mem_rdata = rd_fix;
      end
    end else if (spur_en && $urandom_range(0, 7) == 0) mem_ready = 1'b1;
  endtask

  task automatic drive_req();
    if (i_ready) i_pend = 0;
    if (d_ready) d_pend = 0;
    if (!i_pend && (i_mode == 2 || (i_mode == 1 && $urandom_range(0, 3) == 0))) begin
      i_pend = 1;
      i_addr = {1'b0, 27'($urandom)};
    end
    if (!d_pend && (d_mode == 2 || (d_mode == 1 && $urandom_range(0, 3) == 0))) begin
      d_pend  = 1;
      d_addr  = {1'b1, 27'($urandom)};
      d_wdata = {$urandom, $urandom, $urandom, $urandom};
      d_is_wr = bit'($urandom_range(0, 1));
      d_both  = d_is_wr && ($urandom_range(0, 7) == 0);
    end
    i_read  = i_pend;
    d_write = d_pend && d_is_wr;
    d_read  = d_pend && (!d_is_wr || d_both);
  endtask

  // Advance the model across the upcoming posedge using the inputs just driven.
  task automatic model_step();
    int side, nresp;
    if (rst_n) begin
      m_owner = 0; m_resp = 0; m_last = 1; m_rd = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
      return;
    end
    nresp = 0;
    if (m_owner == 0 && m_resp == 0) begin
      side = 0;
      if (i_read && (d_read || d_write)) side = (m_last == 1) ? 2 : 1;
      else if (i_read)                   side = 1;
      else if (d_read || d_write)        side = 2;
      if (side == 1) begin
        m_rd = 1; m_wr = 0; m_addr = i_addr;
      end else if (side == 2) begin
        m_wr = d_write; m_rd = !d_write; m_addr = d_addr; m_wdata = d_wdata;
      end
      if (side != 0) begin m_owner = side; m_last = side; end
    end else if (m_owner != 0 && mem_ready) begin
      if (m_rd) begin
        if (m_owner == 1) m_irdata = mem_rdata;
        else              m_drdata = mem_rdata;
      end
      nresp = m_owner; m_owner = 0; m_rd = 0; m_wr = 0;
    end
    m_resp = nresp;
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("busy",      DW'(busy),      DW'(m_owner != 0 || m_resp != 0));
    chk("mem_read",  DW'(mem_read),  DW'(m_rd));
    chk("mem_write", DW'(mem_write), DW'(m_wr));
    chk("mem_addr",  DW'(mem_addr),  DW'(m_addr));
    if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_ready",   DW'(i_ready),   DW'(m_resp == 1));
    chk("d_ready",   DW'(d_ready),   DW'(m_resp == 2));
    chk("i_rdata",   i_rdata,        m_irdata);
    chk("d_rdata",   d_rdata,        m_drdata);
    if (mem_read && mem_write) chk("strobe_overlap", DW'(1), DW'(0));
    if (i_ready) n_irdy++;
    if (d_ready) n_drdy++;
    if ((mem_read || mem_write) && !strobe_prev) dut_log.push_back(mem_addr[AW-1] ? 2 : 1);
    strobe_prev = mem_read || mem_write;
    rst_n = rst_req;
    drive_mem();
    drive_req();
    model_step();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 60; k++) begin
      if (m_owner == 0 && m_resp == 0 && !i_pend && !d_pend && !mo_out) break;
      cycle();
    end
    chk(tag, DW'(k < 60), DW'(1));
  endtask

  initial begin
    int i0, d0, k;
    int alt_exp[4];
    alt_exp = '{2, 1, 2, 1};

    // Reset with random activity on the inputs.
    rst_req = 1; i_mode = 1; d_mode = 1; spur_en = 1;
    repeat (3) cycle();
    i_mode = 0; d_mode = 0; spur_en = 0; i_pend = 0; d_pend = 0;
    rst_req = 0;
    repeat (6) cycle();
    wait_idle("reset_settle");

    // Lone I-cache read, latency 3.
    i0 = n_irdy; d0 = n_drdy;
    lat_fix = 3; rd_fix_en = 1;
    rd_fix = 128'hDEAD0000_11112222_33334444_0000BEEF;
    i_addr = 28'h0000010; i_pend = 1;
    wait_idle("i_only_done");
    chk("i_only_irdy",  DW'(n_irdy - i0), DW'(1));
    chk("i_only_drdy",  DW'(n_drdy - d0), DW'(0));
    chk("i_only_rdata", i_rdata, rd_fix);

    // Lone D-cache writeback.
    i0 = n_irdy; d0 = n_drdy;
    lat_fix = 2; rd_fix_en = 0;
    d_addr = 28'h0000020; d_wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87655678;
    d_is_wr = 1; d_both = 0; d_pend = 1;
    wait_idle("d_wb_done");
    chk("d_wb_drdy", DW'(n_drdy - d0), DW'(1));
    chk("d_wb_irdy", DW'(n_irdy - i0), DW'(0));

    // Both sides continuously requesting right after reset: D, I, D, I.
    rst_req = 1; cycle(); cycle();
    rst_req = 0; lat_fix = 0;
    dut_log.delete();
    i_mode = 2; d_mode = 2;
    for (k = 0; k < 200 && dut_log.size() < 4; k++) cycle();
    chk("alt_timeout", DW'(dut_log.size() >= 4), DW'(1));
    for (int j = 0; j < 4 && j < dut_log.size(); j++) chk("alt_grant", DW'(dut_log[j]), DW'(alt_exp[j]));
    i_mode = 0; d_mode = 0;
    wait_idle("alt_drain");

    // Reset in the middle of a D read; the memory still answers late.
    d0 = n_drdy;
    lat_fix = 4; d_is_wr = 0; d_both = 0; d_addr = 28'h0000040; d_pend = 1;
    for (k = 0; k < 10 && !mem_read; k++) cycle();
    chk("midrst_issue", DW'(mem_read), DW'(1));
    rst_req = 1; d_pend = 0;
    cycle();
    rst_req = 0;
    repeat (6) cycle();
    chk("midrst_no_rdy", DW'(n_drdy - d0), DW'(0));
    d0 = n_drdy;
    d_addr = 28'h0000044; d_pend = 1;
    wait_idle("midrst_next");
    chk("midrst_next_rdy", DW'(n_drdy - d0), DW'(1));

    // Random traffic with spurious mem_ready and occasional resets.
    lat_fix = 0; spur_en = 1; i_mode = 1; d_mode = 1;
    repeat (2500) begin
      rst_req = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst_req = 0; i_mode = 0; d_mode = 0; spur_en = 0;
    wait_idle("random_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
